lstm_gate_mac: RTL and testbench
================================

Name: lstm_gate_mac

Overview:
Upstream stage of the LSTM accelerator. Computes the four gate pre-activations for every hidden unit j: z_g[j] = sum_k W_g[j][k]*v[k] + b_g[j], where v = {x, h_prev}. The four gates are i, f, g (cell) and o. The result is serialised one hidden unit per output beat, ready to feed the activation/cell-update unit.
Signed fixed-point Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS. Weights are fetched from an external synchronous weight RAM.

Parameters:
DATA_WIDTH, 16, operand/result width, signed fixed point
FRAC_BITS, 8, fractional bits of every operand and result
ACC_WIDTH, 40, signed accumulator width; must be >= 2*DATA_WIDTH+clog2(K+1)
INPUT_SIZE, 8, number of x elements
HIDDEN_SIZE, 16, number of hidden units (output rows)
Derived: K = INPUT_SIZE+HIDDEN_SIZE; AW = clog2(HIDDEN_SIZE*(K+1))

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  pulse; begins a new timestep when IDLE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last row handshake
vec_valid  in  1  operand stream valid
vec_ready  out  1  operand stream ready (LOAD only)
vec_data  in  DATA_WIDTH  x[0..INPUT_SIZE-1] then h_prev[0..HIDDEN_SIZE-1]
w_rd_en  out  1  weight RAM read strobe
w_addr  out  AW  j*(K+1)+k; k=K selects the bias word
w_rdata  in  4*DATA_WIDTH  {o,g,f,i} packed, i in LSBs; valid 1 cycle after w_rd_en
out_valid  out  1  result beat valid
out_ready  in  1  downstream accept
out_idx  out  clog2(HIDDEN_SIZE)  hidden unit j
out_i, out_f, out_g, out_o  out  DATA_WIDTH each  saturated pre-activations

Interface rules: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy, done, vec_ready, w_rd_en and out_valid are 0. w_addr, out_idx and out_* are 0. Accumulators and counters are cleared. The vector buffer is not cleared.
- FSM states: IDLE, LOAD, MAC, DRAIN, OUT, FINISH.
- IDLE:
  - start -> LOAD.
  - vec_valid is ignored; vec_ready=0.
- LOAD:
  - vec_ready=1.
  - Each vec_valid&vec_ready writes buf[cnt], cnt++.
  - After the K-th beat -> MAC with j=0, k=0 and accumulators cleared.
  - Minimum LOAD time is K cycles.
- MAC:
  - w_rd_en=1 every cycle; w_addr=j*(K+1)+k; k runs 0..K.
  - One cycle after issuing column k<K: acc_g += w_rdata_g * buf[k]. The full 2*DATA_WIDTH product is sign-extended to ACC_WIDTH.
  - One cycle after issuing k=K (bias): acc_g += sext(b_g) << FRAC_BITS.
  - After issuing k=K -> DRAIN.
- DRAIN:
  - w_rd_en=0.
  - The bias is absorbed this cycle.
  - -> OUT.
- OUT:
  - out_valid=1. out_* = sat(acc_g >>> FRAC_BITS); arithmetic shift, i.e. truncation toward -inf.
  - Saturation: a value > 2^(DATA_WIDTH-1)-1 gives 0x7FFF; a value < -2^(DATA_WIDTH-1) gives 0x8000.
  - out_* and out_idx are held stable until out_ready.
  - No RAM reads occur while stalled.
  - On handshake: if j<HIDDEN_SIZE-1, then j++, accumulators cleared, -> MAC. Otherwise -> FINISH.
- FINISH:
  - done=1 for one cycle.
  - -> IDLE.
- Latency per row: K+1 issue cycles + 1 drain cycle; out_valid rises K+2 cycles after MAC entry.
- Total latency with no backpressure: K + HIDDEN_SIZE*(K+3) + 1 cycles from the cycle after start to done.
- start while busy is ignored.
- out_ready asserted with out_valid low has no effect.
- Accumulator overflow is excluded by the parameter constraint; wrap-around is not defined.

Optional Feature:
LSTM_MAC_ROUND_EN
- Defined: round-half-up before the shift, out = sat((acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS).
- Undefined: truncation as above.
- Latency is identical in both cases.

Decomposition:
- Package lstm_pkg:
  - FRAC_BITS default
  - state enum type
  - gate index constants GATE_I=0, GATE_F=1, GATE_G=2, GATE_O=3
  - sat_shift function (rounding under the macro)
- Sub-module lstm_mac_lane, instantiated 4x (one per gate):
  - ACC_WIDTH accumulator with clear, mul-acc and bias-acc controls
  - saturated output
- Top level holds: FSM, vector buffer, address generation, handshake.

Test Plan:
1. All weights 0, all biases 0x0100 -> 16 beats, out_idx 0..15, every gate = 0x0100, done one pulse.
2. x[0]=0x0200; W_i[j][0]=0x0180; all else 0 -> out_i=0x0300 for every j; out_f=out_g=out_o=0x0000.
3. Saturation:
   - v all 0x7FFF, W all 0x7FFF -> all gates 0x7FFF.
   - W all 0x8001 -> all gates 0x8000.
4. Backpressure: out_ready low 10 cycles at j=3 -> out_valid held, data/out_idx stable, w_rd_en=0 throughout; j=4 reads resume the cycle after the handshake.
5. rst asserted mid-MAC at j=5 -> same cycle: outputs 0, busy=0. A subsequent start with a full reload gives results matching scenario 2.
6. Rounding, v[0]=0x0001, W_i[j][0]=0x0080:
   - Macro undefined -> out_i=0x0000.
   - Macro defined -> 0x0001.
   - With W=0xFF80: undefined -> 0xFFFF, defined -> 0x0000.

Source files
------------

// File: rtl/lstm_gate_mac_pkg.sv
// Shared types, constants and the saturating output shifter for the LSTM gate MAC.
// Optional macro LSTM_MAC_ROUND_EN switches sat_shift from truncation to round-half-up.
package lstm_pkg;

  localparam int FRAC_BITS_DEF = 8;

  localparam int GATE_I    = 0;
  localparam int GATE_F    = 1;
  localparam int GATE_G    = 2;
  localparam int GATE_O    = 3;
  localparam int NUM_GATES = 4;

  // Working width for sat_shift; wide enough for any sensible ACC_WIDTH.
  localparam int SAT_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_OUT,
    ST_FINISH
  } state_e;

  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      dataWidth,
    input int                      fracBits
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] maxVal;
    logic signed [SAT_W-1:0] minVal;
    logic signed [SAT_W-1:0] one;
    one = $signed(SAT_W'(1));
`ifdef LSTM_MAC_ROUND_EN
    if (fracBits > 0) begin
      shifted = (acc + (one <<< (fracBits - 1))) >>> fracBits;
    end else begin
      shifted = acc;
    end
`else
    shifted = acc >>> fracBits;
`endif
    maxVal = (one <<< (dataWidth - 1)) - one;
    minVal = -maxVal - one;
    if (shifted > maxVal) begin
      return maxVal;
    end else if (shifted < minVal) begin
      return minVal;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/lstm_gate_mac_lane.sv
// One gate's accumulator: clear, weight*operand accumulate, bias accumulate and
// saturated Q-format output (rounding selected by LSTM_MAC_ROUND_EN in lstm_pkg).
module lstm_mac_lane
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         mac_en_i,
  input  logic                         bias_en_i,
  input  logic signed [DATA_WIDTH-1:0] weight_i,
  input  logic signed [DATA_WIDTH-1:0] operand_i,
  output logic        [DATA_WIDTH-1:0] result_o
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [SAT_W-1:0]        satVal;
  logic                           satUnused;

  assign product = weight_i * operand_i;

  // The bias word shares the weight bus; it is aligned to the product's binary point.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + ACC_WIDTH'(product);
    end else if (bias_en_i) begin
      acc_d = acc_q + (ACC_WIDTH'(weight_i) <<< FRAC_BITS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign satVal    = sat_shift(SAT_W'(acc_q), DATA_WIDTH, FRAC_BITS);
  assign result_o  = satVal[DATA_WIDTH-1:0];
  assign satUnused = ^satVal[SAT_W-1:DATA_WIDTH];

endmodule

// File: rtl/lstm_gate_mac.sv
// LSTM gate pre-activation engine: loads {x, h_prev}, streams weights from a synchronous
// RAM into four MAC lanes and emits one saturated row per beat (LSTM_MAC_ROUND_EN: rounding).
module lstm_gate_mac
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int ACC_WIDTH   = 40,
  parameter int INPUT_SIZE  = 8,
  parameter int HIDDEN_SIZE = 16,
  localparam int K  = INPUT_SIZE + HIDDEN_SIZE,
  localparam int AW = $clog2(HIDDEN_SIZE * (K + 1)),
  localparam int IW = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1,
  localparam int KW = $clog2(K + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  input  logic [DATA_WIDTH-1:0]   vec_data,
  output logic                    w_rd_en,
  output logic [AW-1:0]           w_addr,
  input  logic [4*DATA_WIDTH-1:0] w_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic [DATA_WIDTH-1:0]   out_i,
  output logic [DATA_WIDTH-1:0]   out_f,
  output logic [DATA_WIDTH-1:0]   out_g,
  output logic [DATA_WIDTH-1:0]   out_o
);

  state_e state_q, state_d;

  logic [KW-1:0]                cnt_q, cnt_d;
  logic [KW-1:0]                k_q, k_d;
  logic [IW-1:0]                j_q, j_d;
  logic [AW-1:0]                rowBase_q, rowBase_d;
  logic signed [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic                         pendMac_q, pendMac_d;
  logic                         pendBias_q, pendBias_d;
  logic [DATA_WIDTH-1:0]        vecBuf_q [K];
  logic [DATA_WIDTH-1:0]        laneResult [NUM_GATES];

  logic loadBeat, lastLoad, lastCol, lastRow, outFire, laneClear;

  assign loadBeat = vec_valid & vec_ready;
  assign lastLoad = (cnt_q == KW'(K - 1));
  assign lastCol  = (k_q == KW'(K));
  assign lastRow  = (j_q == IW'(HIDDEN_SIZE - 1));
  assign outFire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (loadBeat && lastLoad) state_d = ST_MAC;
      ST_MAC:    if (lastCol) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_OUT;
      ST_OUT:    if (outFire) state_d = lastRow ? ST_FINISH : ST_MAC;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Accumulators are cleared on every transition into MAC so each row starts from zero.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    vec_ready = (state_q == ST_LOAD);
    w_rd_en   = (state_q == ST_MAC);
    out_valid = (state_q == ST_OUT);
    done      = (state_q == ST_FINISH);
    w_addr    = (state_q == ST_MAC) ? (rowBase_q + AW'(k_q)) : '0;
    laneClear = ((state_q == ST_LOAD) && loadBeat && lastLoad) ||
                ((state_q == ST_OUT) && outFire && !lastRow);
  end

  // Read data lags the address by one cycle, so the column's operand and its
  // accumulate/bias intent are registered alongside the issue.
  always_comb begin
    cnt_d      = cnt_q;
    k_d        = '0;
    j_d        = j_q;
    rowBase_d  = rowBase_q;
    opnd_d     = opnd_q;
    pendMac_d  = 1'b0;
    pendBias_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        j_d       = '0;
        rowBase_d = '0;
      end
      ST_LOAD: begin
        if (loadBeat) cnt_d = cnt_q + KW'(1);
        j_d       = '0;
        rowBase_d = '0;
      end
      ST_MAC: begin
        k_d        = k_q + KW'(1);
        pendMac_d  = !lastCol;
        pendBias_d = lastCol;
        opnd_d     = lastCol ? '0 : vecBuf_q[k_q];
      end
      ST_OUT: begin
        if (outFire && !lastRow) begin
          j_d       = j_q + IW'(1);
          rowBase_d = rowBase_q + AW'(K + 1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      k_q        <= '0;
      j_q        <= '0;
      rowBase_q  <= '0;
      opnd_q     <= '0;
      pendMac_q  <= 1'b0;
      pendBias_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      j_q        <= j_d;
      rowBase_q  <= rowBase_d;
      opnd_q     <= opnd_d;
      pendMac_q  <= pendMac_d;
      pendBias_q <= pendBias_d;
    end
  end

  // The operand buffer is deliberately left out of reset; LOAD always rewrites it.
  always_ff @(posedge clk) begin
    if ((state_q == ST_LOAD) && loadBeat) begin
      vecBuf_q[cnt_q] <= vec_data;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : gLane
    lstm_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .ACC_WIDTH (ACC_WIDTH)
    ) uLane (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (laneClear),
      .mac_en_i (pendMac_q),
      .bias_en_i(pendBias_q),
      .weight_i (w_rdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .operand_i(opnd_q),
      .result_o (laneResult[g])
    );
  end

  assign out_idx = j_q;
  assign out_i   = laneResult[GATE_I];
  assign out_f   = laneResult[GATE_F];
  assign out_g   = laneResult[GATE_G];
  assign out_o   = laneResult[GATE_O];

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed scoreboard bench for lstm_gate_mac with a behavioural weight RAM and a
// full-precision reference model (honours LSTM_MAC_ROUND_EN when defined).
module tb_lstm_gate_mac;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int IN   = 8;
  localparam int H    = 16;
  localparam int K    = IN + H;
  localparam int AW   = $clog2(H * (K + 1));
  localparam int LAT  = K + H * (K + 3) + 1;

  typedef struct packed {
    logic [3:0]    idx;
    logic [DW-1:0] gi;
    logic [DW-1:0] gf;
    logic [DW-1:0] gg;
    logic [DW-1:0] go;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          vec_valid;
  logic          vec_ready;
  logic [DW-1:0] vec_data;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [4*DW-1:0] w_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_idx;
  logic [DW-1:0] out_i, out_f, out_g, out_o;

  logic [DW-1:0] wMem [4][H][K+1];
  logic [DW-1:0] vecMem [K];
  exp_t          sb [$];
  int            checks   = 0;
  int            failures = 0;

  lstm_gate_mac dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_data (vec_data),
    .w_rd_en  (w_rd_en),
    .w_addr   (w_addr),
    .w_rdata  (w_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_i    (out_i),
    .out_f    (out_f),
    .out_g    (out_g),
    .out_o    (out_o)
  );

  always #5 clk = ~clk;

  // Synchronous weight RAM: one cycle read latency, {o,g,f,i} packing.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_rdata <= {wMem[3][int'(w_addr) / (K+1)][int'(w_addr) % (K+1)],
                  wMem[2][int'(w_addr) / (K+1)][int'(w_addr) % (K+1)],
                  wMem[1][int'(w_addr) / (K+1)][int'(w_addr) % (K+1)],
                  wMem[0][int'(w_addr) / (K+1)][int'(w_addr) % (K+1)]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] modelGate(input int g, input int j);
    longint acc;
    longint s;
    acc = 0;
    for (int k = 0; k < K; k++) begin
      acc += longint'($signed(wMem[g][j][k])) * longint'($signed(vecMem[k]));
    end
    acc += longint'($signed(wMem[g][j][K])) <<< FRAC;
`ifdef LSTM_MAC_ROUND_EN
    acc += longint'(1) <<< (FRAC - 1);
`endif
    s = acc >>> FRAC;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return DW'(s);
  endfunction

  task automatic setAll(input logic [DW-1:0] w, input logic [DW-1:0] b, input logic [DW-1:0] v);
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < H; j++) begin
        for (int k = 0; k < K; k++) wMem[g][j][k] = w;
        wMem[g][j][K] = b;
      end
    for (int k = 0; k < K; k++) vecMem[k] = v;
  endtask

  task automatic setRandom();
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < H; j++)
        for (int k = 0; k <= K; k++) wMem[g][j][k] = DW'($urandom);
    for (int k = 0; k < K; k++) vecMem[k] = DW'($urandom);
  endtask

  // One timestep: pushes expectations, loads the vector, drains every row.
  task automatic applyStimulus(input string name, input int stallRow, input int stallLen,
                               input int resetRow, input bit checkLatency);
    int   vi, beats, cycles, stallLeft;
    bit   sawDone, resumeCheck;
    exp_t e;
    for (int j = 0; j < H; j++) begin
      e.idx = 4'(j);
      e.gi  = modelGate(0, j);
      e.gf  = modelGate(1, j);
      e.gg  = modelGate(2, j);
      e.go  = modelGate(3, j);
      sb.push_back(e);
    end
    $display("[TB] step %s", name);
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    vi          = 0;
    beats       = 0;
    cycles      = 1;
    stallLeft   = stallLen;
    sawDone     = 1'b0;
    resumeCheck = 1'b0;
    while (!sawDone && cycles < 3000) begin
      if (resumeCheck) begin
        checkOutput({name, " resume_rd_en"}, 32'(w_rd_en), 32'(1));
        checkOutput({name, " resume_addr"}, 32'(w_addr), 32'((stallRow + 1) * (K + 1)));
        resumeCheck = 1'b0;
      end
      if (resetRow >= 0 && w_rd_en && int'(w_addr) == resetRow * (K + 1) + 2) begin
        rst = 1'b1;
        #1;
        checkOutput({name, " rst_busy"}, 32'(busy), 32'(0));
        checkOutput({name, " rst_rd_en"}, 32'(w_rd_en), 32'(0));
        checkOutput({name, " rst_addr"}, 32'(w_addr), 32'(0));
        checkOutput({name, " rst_idx"}, 32'(out_idx), 32'(0));
        checkOutput({name, " rst_out_i"}, 32'(out_i), 32'(0));
        checkOutput({name, " rst_beats"}, 32'(beats), 32'(resetRow));
        vec_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        return;
      end
      start     = (cycles == 50);
      vec_valid = (vi < K);
      vec_data  = (vi < K) ? vecMem[vi] : '0;
      if (vec_valid && vec_ready) vi++;
      out_ready = 1'b1;
      if (out_valid) begin
        e = (sb.size() > 0) ? sb[0] : '0;
        if (beats == stallRow && stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
          checkOutput({name, " stall_rd_en"}, 32'(w_rd_en), 32'(0));
          checkOutput({name, " stall_idx"}, 32'(out_idx), 32'(e.idx));
          checkOutput({name, " stall_out_i"}, 32'(out_i), 32'(e.gi));
        end else begin
          checkOutput({name, " sb_nonempty"}, 32'(sb.size() > 0), 32'(1));
          if (sb.size() > 0) void'(sb.pop_front());
          checkOutput({name, " out_idx"}, 32'(out_idx), 32'(e.idx));
          checkOutput({name, " out_i"}, 32'(out_i), 32'(e.gi));
          checkOutput({name, " out_f"}, 32'(out_f), 32'(e.gf));
          checkOutput({name, " out_g"}, 32'(out_g), 32'(e.gg));
          checkOutput({name, " out_o"}, 32'(out_o), 32'(e.go));
          if (beats == stallRow && stallLen > 0 && beats < H - 1) resumeCheck = 1'b1;
          beats++;
        end
      end
      if (done) begin
        sawDone = 1'b1;
        checkOutput({name, " beats_at_done"}, 32'(beats), 32'(H));
        if (checkLatency) checkOutput({name, " latency"}, 32'(cycles), 32'(LAT));
      end
      @(negedge clk);
      cycles++;
    end
    start     = 1'b0;
    vec_valid = 1'b0;
    checkOutput({name, " done_seen"}, 32'(sawDone), 32'(1));
    checkOutput({name, " done_pulse"}, 32'(done), 32'(0));
    checkOutput({name, " idle_busy"}, 32'(busy), 32'(0));
    sb.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset done", 32'(done), 32'(0));
    checkOutput("reset vec_ready", 32'(vec_ready), 32'(0));
    checkOutput("reset w_rd_en", 32'(w_rd_en), 32'(0));
    checkOutput("reset out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset w_addr", 32'(w_addr), 32'(0));
    checkOutput("reset out_idx", 32'(out_idx), 32'(0));
    checkOutput("reset out_i", 32'(out_i), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    vec_valid = 1'b1;
    vec_data  = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle vec_ready", 32'(vec_ready), 32'(0));
    end
    vec_valid = 1'b0;

    setAll(16'h0000, 16'h0100, 16'h1234);
    applyStimulus("bias_only", -1, 0, -1, 1'b1);

    setAll(16'h0000, 16'h0000, 16'h0000);
    vecMem[0] = 16'h0200;
    for (int j = 0; j < H; j++) wMem[0][j][0] = 16'h0180;
    checkOutput("model scenario2", 32'(modelGate(0, 7)), 32'h0300);
    applyStimulus("single_term", -1, 0, -1, 1'b1);

    setAll(16'h7FFF, 16'h7FFF, 16'h7FFF);
    applyStimulus("sat_pos", -1, 0, -1, 1'b1);
    setAll(16'h8001, 16'h8001, 16'h7FFF);
    applyStimulus("sat_neg", -1, 0, -1, 1'b1);

    setRandom();
    applyStimulus("backpressure", 3, 10, -1, 1'b0);

    setAll(16'h0000, 16'h0000, 16'h0000);
    vecMem[0] = 16'h0200;
    for (int j = 0; j < H; j++) wMem[0][j][0] = 16'h0180;
    applyStimulus("reset_mid_mac", -1, 0, 5, 1'b0);
    @(negedge clk);
    applyStimulus("after_reset", -1, 0, -1, 1'b1);

    setAll(16'h0000, 16'h0000, 16'h0000);
    vecMem[0] = 16'h0001;
    for (int j = 0; j < H; j++) wMem[0][j][0] = 16'h0080;
`ifdef LSTM_MAC_ROUND_EN
    checkOutput("model round_pos", 32'(modelGate(0, 0)), 32'h0001);
`else
    checkOutput("model round_pos", 32'(modelGate(0, 0)), 32'h0000);
`endif
    applyStimulus("round_pos", -1, 0, -1, 1'b1);
    for (int j = 0; j < H; j++) wMem[0][j][0] = 16'hFF80;
`ifdef LSTM_MAC_ROUND_EN
    checkOutput("model round_neg", 32'(modelGate(0, 0)), 32'h0000);
`else
    checkOutput("model round_neg", 32'(modelGate(0, 0)), 32'hFFFF);
`endif
    applyStimulus("round_neg", -1, 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
